// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and flush handling.
// Latency: 1 cycle ID->EX; stall and flush_ifid are combinational from current inputs and registered state.
// Backpressure: stall holds PC and IF/ID for exactly one cycle per load-use; flush overrides and squashes IF/ID.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   id_*                  decoded instruction fields from the decode slot
//   flush                 redirect from EX (taken branch/jump)
//   ex_*                  registered fields presented to EX / forwarding unit
//   stall, flush_ifid     hazard controls back to fetch/decode
//   bubble_cnt            saturating count of inserted bubbles (only with ID_EX_BUBBLE_COUNT_EN)
module id_ex_stage #(
    parameter int DATA_W = 8,
    parameter int CTRL_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              flush,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_memtoreg,
    output logic              ex_valid,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [DATA_W-1:0] ex_rs1_data,
    output logic [DATA_W-1:0] ex_rs2_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
`ifdef ID_EX_BUBBLE_COUNT_EN
    output logic [15:0]       bubble_cnt,
`endif
    output logic              stall,
    output logic              flush_ifid
);

    localparam logic ST_RUN    = 1'b0;
    localparam logic ST_BUBBLE = 1'b1;

    logic state_q, state_d;

    logic              ex_valid_q, ex_valid_d;
    logic [4:0]        ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
    logic [DATA_W-1:0] ex_rs1_data_q, ex_rs1_data_d;
    logic [DATA_W-1:0] ex_rs2_data_q, ex_rs2_data_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_memread_q, ex_memread_d;
    logic              ex_memwrite_q, ex_memwrite_d;
    logic              ex_memtoreg_q, ex_memtoreg_d;

    logic hz;
    logic load_bubble;

    // Load in EX whose destination is a source the decode slot really reads.
    always_comb begin
        hz = id_valid & ex_valid_q & ex_memread_q & (ex_rd_q != 5'd0) &
             ((id_use_rs1 & (id_rs1 == ex_rd_q)) | (id_use_rs2 & (id_rs2 == ex_rd_q)));
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // FSM: next state; flush always returns to RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (hz && !flush) state_d = ST_BUBBLE;
            ST_BUBBLE: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
        if (flush) state_d = ST_RUN;
    end

    // FSM: outputs. BUBBLE masks hz so one load never stalls twice; rst_n gating keeps both low in reset.
    always_comb begin
        stall      = rst_n & hz & ~flush & (state_q == ST_RUN);
        flush_ifid = rst_n & flush;
    end

    assign load_bubble = flush | stall | ~id_valid;

    // Next EX contents: all-zero bubble, or the decode fields with x0 writes suppressed.
    always_comb begin
        ex_valid_d    = 1'b0;
        ex_rs1_d      = '0;
        ex_rs2_d      = '0;
        ex_rd_d       = '0;
        ex_rs1_data_d = '0;
        ex_rs2_data_d = '0;
        ex_imm_d      = '0;
        ex_ctrl_d     = '0;
        ex_regwrite_d = 1'b0;
        ex_memread_d  = 1'b0;
        ex_memwrite_d = 1'b0;
        ex_memtoreg_d = 1'b0;
        if (!load_bubble) begin
            ex_valid_d    = 1'b1;
            ex_rs1_d      = id_rs1;
            ex_rs2_d      = id_rs2;
            ex_rd_d       = id_rd;
            ex_rs1_data_d = id_rs1_data;
            ex_rs2_data_d = id_rs2_data;
            ex_imm_d      = id_imm;
            ex_ctrl_d     = id_ctrl;
            ex_regwrite_d = id_regwrite & (id_rd != 5'd0);
            ex_memread_d  = id_memread;
            ex_memwrite_d = id_memwrite;
            ex_memtoreg_d = id_memtoreg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_ctrl_q     <= '0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_memwrite_q <= 1'b0;
            ex_memtoreg_q <= 1'b0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rd_q       <= ex_rd_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_imm_q      <= ex_imm_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memread_q  <= ex_memread_d;
            ex_memwrite_q <= ex_memwrite_d;
            ex_memtoreg_q <= ex_memtoreg_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_rs1      = ex_rs1_q;
    assign ex_rs2      = ex_rs2_q;
    assign ex_rd       = ex_rd_q;
    assign ex_rs1_data = ex_rs1_data_q;
    assign ex_rs2_data = ex_rs2_data_q;
    assign ex_imm      = ex_imm_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign ex_regwrite = ex_regwrite_q;
    assign ex_memread  = ex_memread_q;
    assign ex_memwrite = ex_memwrite_q;
    assign ex_memtoreg = ex_memtoreg_q;

`ifdef ID_EX_BUBBLE_COUNT_EN
    // Counts only bubbles caused by a hazard or a flush, not empty decode slots.
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if ((flush || stall) && (bubble_cnt_q != 16'hFFFF))
            bubble_cnt_d = bubble_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bubble_cnt_q <= 16'd0;
        else        bubble_cnt_q <= bubble_cnt_d;
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vectors with literal expectations, plus a
// per-cycle comparison of all outputs against a behavioural pipeline model.
module tb_id_ex_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0, flush = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic [7:0] id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic [5:0] id_ctrl = '0;
    logic       id_regwrite = 1'b0, id_memread = 1'b0, id_memwrite = 1'b0, id_memtoreg = 1'b0;

    logic       ex_valid;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [7:0] ex_rs1_data, ex_rs2_data, ex_imm;
    logic [5:0] ex_ctrl;
    logic       ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic       stall, flush_ifid;
`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [15:0] bubble_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    id_ex_stage #(.DATA_W(8), .CTRL_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .flush(flush),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_memtoreg(id_memtoreg),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg),
`ifdef ID_EX_BUBBLE_COUNT_EN
        .bubble_cnt(bubble_cnt),
`endif
        .stall(stall), .flush_ifid(flush_ifid)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       v;
        logic [4:0] rs1, rs2, rd;
        logic [7:0] d1, d2, imm;
        logic [5:0] ctrl;
        logic       rw, mr, mw, mt;
    } ex_t;

    ex_t         m_ex = '0;
    logic        m_stalled_last = 1'b0;  // previous cycle already stalled for a load
    logic [15:0] m_cnt = '0;

    function automatic logic model_stall();
        logic uses_load;
        uses_load = (id_use_rs1 && id_rs1 == m_ex.rd) || (id_use_rs2 && id_rs2 == m_ex.rd);
        return rst_n && id_valid && m_ex.v && m_ex.mr && (m_ex.rd != 0) && uses_load
               && !flush && !m_stalled_last;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex = '0;
            m_stalled_last = 1'b0;
            m_cnt = '0;
        end else begin
            logic st;
            st = model_stall();
            if (flush || st || !id_valid) m_ex = '0;
            else begin
                m_ex.v = 1'b1;
                m_ex.rs1 = id_rs1; m_ex.rs2 = id_rs2; m_ex.rd = id_rd;
                m_ex.d1 = id_rs1_data; m_ex.d2 = id_rs2_data; m_ex.imm = id_imm;
                m_ex.ctrl = id_ctrl;
                m_ex.rw = id_regwrite && (id_rd != 0);
                m_ex.mr = id_memread; m_ex.mw = id_memwrite; m_ex.mt = id_memtoreg;
            end
            if ((flush || st) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
            m_stalled_last = st;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cyc_ex", 64'({ex_valid, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm,
                          ex_ctrl, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}),
            64'(m_ex));
        chk("cyc_stall", 64'(stall), 64'(model_stall()));
        chk("cyc_flush_ifid", 64'(flush_ifid), 64'(rst_n && flush));
`ifdef ID_EX_BUBBLE_COUNT_EN
        chk("cyc_cnt", 64'(bubble_cnt), 64'(m_cnt));
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic u1, input logic u2,
                          input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] imm,
                          input logic [5:0] ctrl, input logic rw, input logic mr,
                          input logic mw, input logic mt);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_ctrl = ctrl;
        id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_memtoreg = mt;
    endtask

    task automatic id_lw(input logic [4:0] rd);
        set_id(1, 5'd2, 5'd0, rd, 1, 0, 8'h10, 8'h00, 8'h04, 6'h01, 1, 1, 0, 1);
    endtask

    task automatic id_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        set_id(1, rs1, rs2, rd, 1, 1, 8'hA5, 8'h5A, 8'h00, 6'h22, 1, 0, 0, 0);
    endtask

    initial begin
        // Reset: outputs low even with flush asserted.
        flush = 1'b1;
        #2;
        chk("rst_ex_valid", 64'(ex_valid), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_flush_ifid", 64'(flush_ifid), 64'd0);
        flush = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Pass-through.
        set_id(1, 5'd1, 5'd2, 5'd5, 1, 0, 8'h3C, 8'h11, 8'h22, 6'h15, 1, 0, 0, 0);
        tick();
        chk("pt_ex_rd", 64'(ex_rd), 64'd5);
        chk("pt_ex_rs1_data", 64'(ex_rs1_data), 64'h3C);
        chk("pt_ex_regwrite", 64'(ex_regwrite), 64'd1);
        chk("pt_ex_ctrl", 64'(ex_ctrl), 64'h15);

        // Load-use: lw x3, then add x6,x3,x4.
        id_lw(5'd3);
        #1 chk("pt_stall", 64'(stall), 64'd0);
        tick();
        chk("lw_ex_memread", 64'(ex_memread), 64'd1);
        chk("lw_ex_rd", 64'(ex_rd), 64'd3);
        id_add(5'd6, 5'd3, 5'd4);
        #1 chk("lu_stall", 64'(stall), 64'd1);
        tick();
        chk("lu_bubble_valid", 64'(ex_valid), 64'd0);
        chk("lu_bubble_rd", 64'(ex_rd), 64'd0);
        #1 chk("lu_stall_released", 64'(stall), 64'd0);
        tick();
        chk("lu_add_valid", 64'(ex_valid), 64'd1);
        chk("lu_add_rd", 64'(ex_rd), 64'd6);
        chk("lu_add_rs1", 64'(ex_rs1), 64'd3);

        // No false hazard: load to x0 (regwrite suppressed), then reader of x0.
        id_lw(5'd0);
        tick();
        chk("x0_ex_regwrite", 64'(ex_regwrite), 64'd0);
        chk("x0_ex_memread", 64'(ex_memread), 64'd1);
        set_id(1, 5'd0, 5'd7, 5'd8, 1, 1, 8'h01, 8'h02, 8'h03, 6'h04, 1, 0, 0, 0);
        #1 chk("x0_no_stall", 64'(stall), 64'd0);
        id_lw(5'd3);
        tick();
        set_id(1, 5'd7, 5'd3, 5'd9, 1, 0, 8'h01, 8'h02, 8'h03, 6'h04, 1, 0, 0, 0);
        #1 chk("unused_rs2_no_stall", 64'(stall), 64'd0);
        id_use_rs2 = 1'b1;
        #1 chk("used_rs2_stall", 64'(stall), 64'd1);

        // Flush beats hazard.
        flush = 1'b1;
        #1;
        chk("fl_stall", 64'(stall), 64'd0);
        chk("fl_flush_ifid", 64'(flush_ifid), 64'd1);
        tick();
        chk("fl_ex_valid", 64'(ex_valid), 64'd0);
        flush = 1'b0;
        id_lw(5'd3);
        tick();
        id_add(5'd6, 5'd3, 5'd4);
        #1 chk("fl_back_in_run", 64'(stall), 64'd1);

        // Reset mid-BUBBLE with a fresh instruction waiting in decode.
        tick();
        id_add(5'd12, 5'd1, 5'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rb_ex_all", 64'({ex_valid, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm,
                             ex_ctrl, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}), 64'd0);
        chk("rb_stall", 64'(stall), 64'd0);
        tick();
        rst_n = 1'b1;
        id_lw(5'd3);
        tick();
        // Async clear of live data between edges.
        #2 rst_n = 1'b0;
        #1 chk("ra_ex_rs1_data", 64'(ex_rs1_data), 64'd0);
        chk("ra_ex_memread", 64'(ex_memread), 64'd0);
        tick();
        rst_n = 1'b1;
        id_add(5'd6, 5'd3, 5'd4);
        #1 chk("ra_stall_after_release", 64'(stall), 64'd0);
        tick();

`ifdef ID_EX_BUBBLE_COUNT_EN
        rst_n = 1'b0;
        #1 chk("cnt_reset", 64'(bubble_cnt), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_lw(5'd3);
            tick();
            id_add(5'd6, 5'd3, 5'd4);
            tick();
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
            tick();
        end
        chk("cnt_five", 64'(bubble_cnt), 64'd5);
        force dut.bubble_cnt_q = 16'hFFFE;
        m_cnt = 16'hFFFE;
        #1 release dut.bubble_cnt_q;
        flush = 1'b1;
        repeat (3) tick();
        flush = 1'b0;
        chk("cnt_saturate", 64'(bubble_cnt), 64'hFFFF);
        tick();
`endif

        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
